// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-operation sequencer and its ALU.
package reg_seq_pkg;

    localparam int W_DEF = 16;
    localparam int IMM_W = 8;

    typedef enum logic [1:0] {
        OP_MOVI = 2'd0,
        OP_ADD  = 2'd1,
        OP_AND  = 2'd2,
        OP_MVN  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/reg_op_sequencer_alu16.sv
// Combinational ALU for the sequencer: ADD with signed-overflow flag, AND, MVN (~B).
module alu16
    import reg_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  op_t          op,
    output logic [W-1:0] C,
    output logic         V
);

    always_comb begin
        C = '0;
        V = 1'b0;
        case (op)
            OP_ADD: begin
                C = A + B;
                // Overflow when both operands share a sign the sum does not.
                V = (A[W-1] == B[W-1]) && (C[W-1] != A[W-1]);
            end
            OP_AND:  C = A & B;
            OP_MVN:  C = ~B;
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Multi-cycle register-file instruction sequencer (MOVI/ADD/AND/MVN).
// Optional flag registers are built when REG_SEQ_STATUS_EN is defined.
module reg_op_sequencer
    import reg_seq_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int NREG_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [NREG_BITS-1:0] rd,
    input  logic [NREG_BITS-1:0] rn,
    input  logic [NREG_BITS-1:0] rm,
    input  logic [IMM_W-1:0]     imm8,
    output logic [NREG_BITS-1:0] readnum,
    input  logic [W-1:0]         rf_rdata,
    output logic [NREG_BITS-1:0] writenum,
    output logic                 write,
    output logic [W-1:0]         data_in,
    output logic                 done,
    output logic [2:0]           status,
    output logic [2:0]           dbg_state
);

    // Handshake: an instruction transfers on a posedge with in_valid && in_ready;
    // in_ready is high only in IDLE and in_valid elsewhere is simply dropped.

    state_t               state_q, state_d;
    op_t                  op_q;
    logic [NREG_BITS-1:0] rd_q, rn_q, rm_q;
    logic [W-1:0]         a_q, b_q, c_q;
    logic [W-1:0]         alu_c;
    logic                 alu_v;
    logic [W-1:0]         imm_sext;

    assign imm_sext  = {{(W-IMM_W){imm8[IMM_W-1]}}, imm8};
    assign dbg_state = state_q;

    alu16 #(.W(W)) u_alu (
        .A  (a_q),
        .B  (b_q),
        .op (op_q),
        .C  (alu_c),
        .V  (alu_v)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MOVI;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_t'(op);
                        rd_q <= rd;
                        rn_q <= rn;
                        rm_q <= rm;
                        // MOVI skips the datapath, so its result is captured here.
                        if (op_t'(op) == OP_MOVI) begin
                            c_q <= imm_sext;
                        end
                    end
                end
                S_RD_A:  a_q <= rf_rdata;
                S_RD_B:  b_q <= rf_rdata;
                S_EXEC:  c_q <= alu_c;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        data_in  = '0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (op_t'(op))
                        OP_MOVI: state_d = S_WB;
                        OP_MVN:  state_d = S_RD_B;
                        default: state_d = S_RD_A;
                    endcase
                end
            end
            S_RD_A: begin
                readnum = rn_q;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                readnum = rm_q;
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                write    = 1'b1;
                writenum = rd_q;
                data_in  = c_q;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef REG_SEQ_STATUS_EN
    logic [2:0] status_q;

    // Flags {N,V,Z} follow the ALU result on the EXEC->WB edge; MOVI never visits EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= 3'b000;
        end else if (state_q == S_EXEC) begin
            status_q <= {alu_c[W-1], alu_v, (alu_c == '0)};
        end
    end

    assign status = status_q;
`else
    assign status = 3'b000;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed self-checking bench for reg_op_sequencer with a behavioural register file.
module tb_reg_op_sequencer;

    localparam int W  = 16;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [NB-1:0] rd, rn, rm;
    logic [7:0]    imm8;
    logic [NB-1:0] readnum;
    logic [W-1:0]  rf_rdata;
    logic [NB-1:0] writenum;
    logic          write;
    logic [W-1:0]  data_in;
    logic          done;
    logic [2:0]    status;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Register file model plus a poke port for presetting operands.
    logic [W-1:0]  rf [8];
    logic          poke_en  = 1'b0;
    logic [NB-1:0] poke_idx = '0;
    logic [W-1:0]  poke_val = '0;

    assign rf_rdata = rf[readnum];

    always @(posedge clk) begin
        if (poke_en) rf[poke_idx] <= poke_val;
        else if (write) rf[writenum] <= data_in;
    end

    always #5 clk = ~clk;

    reg_op_sequencer #(.W(W), .NREG_BITS(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm8      (imm8),
        .readnum   (readnum),
        .rf_rdata  (rf_rdata),
        .writenum  (writenum),
        .write     (write),
        .data_in   (data_in),
        .done      (done),
        .status    (status),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] st(input logic [2:0] f);
`ifdef REG_SEQ_STATUS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [NB-1:0] idx, input logic [W-1:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        step();
        poke_en  = 1'b0;
    endtask

    // Offer one instruction; returns positioned one cycle after the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [NB-1:0] d, input logic [NB-1:0] n,
                         input logic [NB-1:0] m, input logic [7:0] imm);
        int budget;
        op = o; rd = d; rn = n; rm = m; imm8 = imm;
        in_valid = 1'b1;
        budget = 0;
        while (!in_ready && budget < 20) begin
            step();
            budget++;
        end
        if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        op = 2'd0; rd = '0; rn = '0; rm = '0; imm8 = '0;
        step();
        step();
        check("rst_ready",    in_ready,  1);
        check("rst_write",    write,     0);
        check("rst_done",     done,      0);
        check("rst_readnum",  readnum,   0);
        check("rst_writenum", writenum,  0);
        check("rst_data_in",  data_in,   0);
        check("rst_status",   status,    0);
        check("rst_state",    dbg_state, 0);
        reset = 1'b0;
        step();

        // MOVI rd=3, imm 0x85 sign-extends to 0xFF85
        issue(2'd0, 3'd3, 3'd0, 3'd0, 8'h85);
        check("movi_write",    write,    1);
        check("movi_writenum", writenum, 3);
        check("movi_data",     data_in,  16'hFF85);
        check("movi_done",     done,     1);
        check("movi_status",   status,   0);
        step();
        check("movi_idle_write", write,    0);
        check("movi_idle_ready", in_ready, 1);
        check("movi_rf3",        rf[3],    16'hFF85);

        // ADD R4 = 0x7FFF + 0x0001 -> 0x8000, signed overflow
        poke(3'd1, 16'h7FFF);
        poke(3'd2, 16'h0001);
        issue(2'd1, 3'd4, 3'd1, 3'd2, 8'h00);
        check("add_rda_readnum", readnum,  1);
        check("add_rda_ready",   in_ready, 0);
        step();
        check("add_rdb_readnum", readnum, 2);
        step();
        check("add_exec_readnum", readnum, 0);
        check("add_exec_write",   write,   0);
        step();
        check("add_wb_write",    write,    1);
        check("add_wb_writenum", writenum, 4);
        check("add_wb_data",     data_in,  16'h8000);
        check("add_wb_status",   status,   st(3'b110));
        step();
        check("add_rf4", rf[4], 16'h8000);

        // MVN R5 = ~R5 with R5 = 0xFFFF -> 0x0000, Z set
        poke(3'd5, 16'hFFFF);
        issue(2'd3, 3'd5, 3'd0, 3'd5, 8'h00);
        check("mvn_rdb_readnum", readnum, 5);
        step();
        check("mvn_exec_write", write, 0);
        step();
        check("mvn_wb_write",    write,    1);
        check("mvn_wb_writenum", writenum, 5);
        check("mvn_wb_data",     data_in,  16'h0000);
        check("mvn_wb_status",   status,   st(3'b001));
        step();
        check("mvn_rf5", rf[5], 16'h0000);

        // AND R6 = 0x7FFF & 0xFF85 -> 0x7F85, all flags clear
        issue(2'd2, 3'd6, 3'd1, 3'd3, 8'h00);
        step();
        step();
        step();
        check("and_wb_data",     data_in,  16'h7F85);
        check("and_wb_writenum", writenum, 6);
        check("and_wb_status",   status,   st(3'b000));
        step();

        // in_valid held through ADD; inputs change after acceptance
        op = 2'd1; rd = 3'd6; rn = 3'd1; rm = 3'd2; imm8 = 8'h00;
        in_valid = 1'b1;
        step();
        op = 2'd0; rd = 3'd7; rn = 3'd3; rm = 3'd3; imm8 = 8'h01;
        check("hold_rda_ready",   in_ready, 0);
        check("hold_rda_readnum", readnum,  1);
        step();
        check("hold_rdb_ready",   in_ready, 0);
        check("hold_rdb_readnum", readnum,  2);
        step();
        check("hold_exec_ready", in_ready, 0);
        step();
        check("hold_wb_ready",    in_ready, 0);
        check("hold_wb_writenum", writenum, 6);
        check("hold_wb_data",     data_in,  16'h8000);
        step();
        check("hold_idle_ready", in_ready, 1);
        check("hold_idle_write", write,    0);
        step();
        check("hold2_wb_writenum", writenum, 7);
        check("hold2_wb_data",     data_in,  16'h0001);
        in_valid = 1'b0;
        step();
        check("hold2_rf7", rf[7], 16'h0001);

        // Reset during EXEC of AND aborts without writing R3
        issue(2'd2, 3'd3, 3'd1, 3'd2, 8'h00);
        step();
        step();
        check("abort_state_exec", dbg_state, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready",  in_ready,  1);
        check("abort_write",  write,     0);
        check("abort_status", status,    0);
        check("abort_state",  dbg_state, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_write", write, 0);
        end
        check("abort_rf3", rf[3], 16'hFF85);

        // MOVI R0=0x12 then ADD R0 = R0 + R0 back-to-back
        issue(2'd0, 3'd0, 3'd0, 3'd0, 8'h12);
        check("dep_movi_data", data_in, 16'h0012);
        step();
        issue(2'd1, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        step();
        step();
        check("dep_add_writenum", writenum, 0);
        check("dep_add_data",     data_in,  16'h0024);
        check("dep_add_status",   status,   st(3'b000));
        step();
        check("dep_rf0", rf[0], 16'h0024);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
